// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, write
// encodings, interrupt codes and the read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

  typedef enum logic [1:0] {
    WT_NOP   = 2'b00,
    WT_WRITE = 2'b01,
    WT_SET   = 2'b10,
    WT_CLEAR = 2'b11
  } write_type_e;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  // MPP is hardwired to machine mode
  localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;

  localparam logic [31:0] MISA_VALUE         = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK           = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK         = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK          = 32'hFFFF_FFFC;
  localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

  function automatic logic [31:0] csr_apply(input write_type_e op,
                                            input logic [31:0] cur,
                                            input logic [31:0] wdata);
    logic [31:0] nv;
    case (op)
      WT_WRITE: nv = wdata;
      WT_SET:   nv = cur | wdata;
      WT_CLEAR: nv = cur & ~wdata;
      default:  nv = cur;
    endcase
    return nv;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves; a write to
// either half suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo) begin
      count[31:0] <= wdata;
    end else if (wr_hi) begin
      count[63:32] <= wdata;
    end else if (en && inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: trap/mret state, vectored mtvec, interrupt
// enable/pending with fixed priority, and mcycle/minstret counters.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          CAUSE_W      = 5,
  parameter logic [31:0] MTVEC_RESET  = 32'h4,
  parameter logic [31:0] HART_ID      = 32'h0,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        addr,
  input  logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    rdata,
  input  logic               read,
  input  logic               write,
  input  logic [1:0]         write_type,
  output logic               invalid,
  input  logic               trap,
  input  logic               trap_irq,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_val,
  input  logic               ret,
  input  logic               retire,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic               irq_soft,
  output logic [XLEN-1:0]    trap_vector,
  output logic [XLEN-1:0]    mepc_out,
  output logic               irq_req,
  output logic [CAUSE_W-1:0] irq_cause
);

  localparam logic [XLEN-1:0] MCAUSE_MASK =
    {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, {CAUSE_W{1'b1}}};

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] minhibit_q;
  logic [63:0]     mcycle;
  logic [63:0]     minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] pend;
  logic [XLEN-1:0] csr_val;
  logic [XLEN-1:0] wval;
  logic            mapped;
  logic            read_only;
  logic            write_op;
  logic            wr_en;

  always_comb begin
    mstatus_val               = MSTATUS_MPP;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
  end

  assign mip_val = {{(XLEN-12){1'b0}}, irq_ext, 3'b000, irq_timer, 3'b000, irq_soft, 3'b000};

  always_comb begin
    csr_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_only = 1'b1;
      CSR_MHARTID: begin
        csr_val   = HART_ID;
        read_only = 1'b1;
      end
      CSR_MSTATUS: csr_val = mstatus_val;
      CSR_MISA: begin
        csr_val   = MISA_VALUE;
        read_only = 1'b1;
      end
      CSR_MIE:      csr_val = mie_q;
      CSR_MTVEC:    csr_val = mtvec_q;
      CSR_MSCRATCH: csr_val = mscratch_q;
      CSR_MEPC:     csr_val = mepc_q;
      CSR_MCAUSE:   csr_val = mcause_q;
      CSR_MTVAL:    csr_val = mtval_q;
      // writes to mip are accepted and silently dropped
      CSR_MIP:      csr_val = mip_val;
      CSR_MCOUNTINHIBIT: begin
        csr_val = minhibit_q;
        mapped  = HAS_COUNTERS;
      end
      CSR_MCYCLE: begin
        csr_val = mcycle[31:0];
        mapped  = HAS_COUNTERS;
      end
      CSR_MCYCLEH: begin
        csr_val = mcycle[63:32];
        mapped  = HAS_COUNTERS;
      end
      CSR_MINSTRET: begin
        csr_val = minstret[31:0];
        mapped  = HAS_COUNTERS;
      end
      CSR_MINSTRETH: begin
        csr_val = minstret[63:32];
        mapped  = HAS_COUNTERS;
      end
      default: mapped = 1'b0;
    endcase
  end

  assign write_op = write && (write_type != WT_NOP);
  assign invalid  = (read || write) && (!mapped || (write_op && read_only));
  assign wr_en    = write_op && mapped && !read_only && !trap && !ret;
  assign wval     = csr_apply(write_type_e'(write_type), csr_val, wdata);
  assign rdata    = read ? csr_val : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      minhibit_q   <= '0;
    end else if (trap) begin
      mepc_q       <= trap_pc & MEPC_MASK;
      mcause_q     <= {trap_irq, {(XLEN-1-CAUSE_W){1'b0}}, trap_cause};
      mtval_q      <= trap_irq ? '0 : trap_val;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (ret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en) begin
      case (addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= wval[MSTATUS_MIE];
          mstatus_mpie <= wval[MSTATUS_MPIE];
        end
        CSR_MIE:           mie_q      <= wval & MIE_MASK;
        CSR_MTVEC:         mtvec_q    <= wval & MTVEC_MASK;
        CSR_MSCRATCH:      mscratch_q <= wval;
        CSR_MEPC:          mepc_q     <= wval & MEPC_MASK;
        CSR_MCAUSE:        mcause_q   <= wval & MCAUSE_MASK;
        CSR_MTVAL:         mtval_q    <= wval;
        CSR_MCOUNTINHIBIT: minhibit_q <= wval & MCOUNTINHIBIT_MASK;
        default: ;
      endcase
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    csr_counter64 u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!minhibit_q[0]),
      .inc   (1'b1),
      .wr_lo (wr_en && (addr == CSR_MCYCLE)),
      .wr_hi (wr_en && (addr == CSR_MCYCLEH)),
      .wdata (wval),
      .count (mcycle)
    );

    csr_counter64 u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!minhibit_q[2]),
      .inc   (retire),
      .wr_lo (wr_en && (addr == CSR_MINSTRET)),
      .wr_hi (wr_en && (addr == CSR_MINSTRETH)),
      .wdata (wval),
      .count (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

  assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00} +
                       ((mtvec_q[0] && trap_irq) ?
                        {{(XLEN-CAUSE_W-2){1'b0}}, trap_cause, 2'b00} : '0);
  assign mepc_out = mepc_q;

  assign pend    = mip_val & mie_q;
  assign irq_req = mstatus_mie && (|pend);

  // fixed priority: external, then software, then timer
  always_comb begin
    irq_cause = '0;
    if (pend[IRQ_MEI])      irq_cause = CAUSE_W'(IRQ_MEI);
    else if (pend[IRQ_MSI]) irq_cause = CAUSE_W'(IRQ_MSI);
    else if (pend[IRQ_MTI]) irq_cause = CAUSE_W'(IRQ_MTI);
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: reset checks, a write/read vector
// table, hand-written trap/counter/reset sequences and a random phase.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  write_type = '0;
  logic        invalid;
  logic        trap = 1'b0;
  logic        trap_irq = 1'b0;
  logic [4:0]  trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_val = '0;
  logic        ret = 1'b0;
  logic        retire = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_soft = 1'b0;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        irq_req;
  logic [4:0]  irq_cause;

  always #5 clk = ~clk;

  csr_file_m dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rdata(rdata),
    .read(read), .write(write), .write_type(write_type), .invalid(invalid),
    .trap(trap), .trap_irq(trap_irq), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val), .ret(ret), .retire(retire),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .trap_vector(trap_vector), .mepc_out(mepc_out), .irq_req(irq_req),
    .irq_cause(irq_cause)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference state
  bit          m_mie_b, m_mpie_b;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
  logic [63:0] m_cycle, m_instret;

  task automatic model_reset();
    m_mie_b = 0; m_mpie_b = 0;
    m_mie = 0; m_mtvec = 32'h4; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_inh = 0; m_cycle = 0; m_instret = 0;
  endtask

  task automatic model_lookup(input logic [11:0] a, output logic [31:0] v,
                              output bit mapped, output bit ro);
    v = 0; mapped = 1; ro = 0;
    case (a)
      12'hF11, 12'hF12, 12'hF13, 12'hF14: ro = 1;
      12'h300: v = 32'h1800 | (32'(m_mie_b) << 3) | (32'(m_mpie_b) << 7);
      12'h301: begin v = 32'h4000_0100; ro = 1; end
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h320: v = m_inh;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      default: mapped = 0;
    endcase
  endtask

  task automatic model_compare();
    logic [31:0] v, pend, exp_vec;
    bit mapped, ro, exp_inv;
    int exp_cause;
    model_lookup(addr, v, mapped, ro);
    exp_inv = (read || write) && (!mapped || (write && write_type != 0 && ro));
    check("rnd_rdata", rdata, read ? v : 32'h0);
    check("rnd_invalid", 32'(invalid), 32'(exp_inv));
    pend = m_mie & ((32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3));
    exp_cause = pend[11] ? 11 : pend[3] ? 3 : pend[7] ? 7 : 0;
    check("rnd_irq_req", 32'(irq_req), 32'(m_mie_b && pend != 0));
    check("rnd_irq_cause", 32'(irq_cause), 32'(exp_cause));
    exp_vec = (m_mtvec & ~32'h3) + ((m_mtvec[0] && trap_irq) ? 32'(trap_cause) * 4 : 0);
    check("rnd_trap_vector", trap_vector, exp_vec);
    check("rnd_mepc_out", mepc_out, m_mepc);
  endtask

  task automatic model_step();
    logic [31:0] cur, nv;
    bit mapped, ro, wr_eff, cyc_wr, ins_wr;
    model_lookup(addr, cur, mapped, ro);
    wr_eff = write && write_type != 0 && mapped && !ro && !trap && !ret;
    case (write_type)
      2'b01:   nv = wdata;
      2'b10:   nv = cur | wdata;
      2'b11:   nv = cur & ~wdata;
      default: nv = cur;
    endcase
    cyc_wr = wr_eff && (addr == 12'hB00 || addr == 12'hB80);
    ins_wr = wr_eff && (addr == 12'hB02 || addr == 12'hB82);
    if (!cyc_wr && !m_inh[0]) m_cycle = m_cycle + 1;
    if (!ins_wr && !m_inh[2] && retire) m_instret = m_instret + 1;
    if (trap) begin
      m_mepc   = trap_pc & ~32'h3;
      m_mcause = (32'(trap_irq) << 31) | 32'(trap_cause);
      m_mtval  = trap_irq ? 32'h0 : trap_val;
      m_mpie_b = m_mie_b;
      m_mie_b  = 0;
    end else if (ret) begin
      m_mie_b  = m_mpie_b;
      m_mpie_b = 1;
    end else if (wr_eff) begin
      case (addr)
        12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
        12'h304: m_mie = nv & 32'h888;
        12'h305: m_mtvec = nv & ~32'h2;
        12'h320: m_inh = nv & 32'h5;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv & 32'h8000_001F;
        12'h343: m_mtval = nv;
        12'hB00: m_cycle[31:0] = nv;
        12'hB80: m_cycle[63:32] = nv;
        12'hB02: m_instret[31:0] = nv;
        12'hB82: m_instret[63:32] = nv;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit chk);
    #2;
    if (chk) model_compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] t, input logic [31:0] d);
    addr = a; write = 1; write_type = t; wdata = d;
    step(0);
    write = 0; write_type = 0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    addr = a; read = 1;
    #1;
    check(name, rdata, exp);
    read = 0;
  endtask

  typedef struct {
    logic [11:0] a;
    logic [1:0]  t;
    logic [31:0] d;
    logic        exp_inv;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic [11:0] a, logic [1:0] t, logic [31:0] d,
                                  logic inv, logic [31:0] e, string n);
    vec_t v;
    v.a = a; v.t = t; v.d = d; v.exp_inv = inv; v.exp_rd = e; v.name = n;
    vecs.push_back(v);
  endfunction

  localparam logic [11:0] RND_ADDRS [20] = '{
    12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
    12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80,
    12'hB02, 12'hB82, 12'h7C0, 12'h000};

  initial begin
    add_vec(12'h340, 2'b01, 32'hF0F0_0000, 0, 32'hF0F0_0000, "mscratch_write");
    add_vec(12'h340, 2'b10, 32'h0000_00FF, 0, 32'hF0F0_00FF, "mscratch_set");
    add_vec(12'h340, 2'b11, 32'hF000_0000, 0, 32'h00F0_00FF, "mscratch_clear");
    add_vec(12'h304, 2'b01, 32'hFFFF_FFFF, 0, 32'h0000_0888, "mie_mask");
    add_vec(12'h304, 2'b11, 32'h0000_0008, 0, 32'h0000_0880, "mie_clear");
    add_vec(12'h305, 2'b01, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFD, "mtvec_mask");
    add_vec(12'h341, 2'b01, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, "mepc_mask");
    add_vec(12'h342, 2'b01, 32'hFFFF_FFFF, 0, 32'h8000_001F, "mcause_mask");
    add_vec(12'h343, 2'b01, 32'h1234_5678, 0, 32'h1234_5678, "mtval_write");
    add_vec(12'h300, 2'b01, 32'hFFFF_FFFF, 0, 32'h0000_1888, "mstatus_all");
    add_vec(12'h300, 2'b01, 32'h0000_0000, 0, 32'h0000_1800, "mstatus_zero");
    add_vec(12'hF14, 2'b01, 32'h0000_0005, 1, 32'h0000_0000, "mhartid_ro");
    add_vec(12'h301, 2'b01, 32'h0000_0000, 1, 32'h4000_0100, "misa_ro");
    add_vec(12'h301, 2'b00, 32'hFFFF_FFFF, 0, 32'h4000_0100, "misa_nop");
    add_vec(12'h344, 2'b01, 32'h0000_0FFF, 0, 32'h0000_0000, "mip_ignored");
    add_vec(12'h7C0, 2'b10, 32'h0000_0001, 1, 32'h0000_0000, "unmapped_wr");
    add_vec(12'h320, 2'b01, 32'hFFFF_FFFF, 0, 32'h0000_0005, "inhibit_mask");
    add_vec(12'h320, 2'b11, 32'hFFFF_FFFF, 0, 32'h0000_0000, "inhibit_clear");

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // reset state
    rd(12'h305, 32'h4, "rst_mtvec");
    check("rst_mtvec_invalid", 32'(invalid), 0);
    addr = 12'h7C0; read = 1; #1;
    check("rst_unmapped_invalid", 32'(invalid), 1);
    check("rst_unmapped_rdata", rdata, 0);
    read = 0; addr = 12'h305; #1;
    check("rst_rdata_noread", rdata, 0);
    check("rst_irq_req", 32'(irq_req), 0);
    check("rst_mepc_out", mepc_out, 0);
    step(0);

    foreach (vecs[i]) begin
      addr = vecs[i].a; write = 1; write_type = vecs[i].t; wdata = vecs[i].d;
      #1;
      check({vecs[i].name, "_invalid"}, 32'(invalid), 32'(vecs[i].exp_inv));
      step(0);
      write = 0; write_type = 0;
      rd(vecs[i].a, vecs[i].exp_rd, vecs[i].name);
      step(0);
    end

    // interrupt request and vectored trap
    wr(12'h305, 2'b01, 32'h101);
    wr(12'h304, 2'b01, 32'h800);
    wr(12'h300, 2'b10, 32'h8);
    irq_ext = 1; #1;
    check("irq_req_ext", 32'(irq_req), 1);
    check("irq_cause_ext", 32'(irq_cause), 11);
    trap = 1; trap_irq = 1; trap_cause = 5'd11; trap_pc = 32'h2002; trap_val = 32'hDEAD; #1;
    check("trap_vector_vec", trap_vector, 32'h12C);
    step(0);
    trap = 0; trap_irq = 0; trap_cause = 5'd5; #1;
    check("trap_vector_exc", trap_vector, 32'h100);
    check("irq_req_after_trap", 32'(irq_req), 0);
    check("trap_mepc", mepc_out, 32'h2000);
    rd(12'h342, 32'h8000_000B, "trap_mcause");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    rd(12'h343, 32'h0, "trap_mtval_irq");
    step(0);
    ret = 1;
    step(0);
    ret = 0;
    rd(12'h300, 32'h0000_1888, "ret_mstatus");
    check("irq_req_after_ret", 32'(irq_req), 1);
    step(0);
    irq_ext = 0;

    // trap beats ret beats CSR write
    trap = 1; trap_irq = 0; trap_cause = 5'd2; trap_pc = 32'h3006; trap_val = 32'hBAD;
    ret = 1; addr = 12'h341; write = 1; write_type = 2'b01; wdata = 32'h5550;
    step(0);
    trap = 0; ret = 0; write = 0; write_type = 0;
    check("prec_mepc", mepc_out, 32'h3004);
    rd(12'h343, 32'hBAD, "prec_mtval");
    rd(12'h342, 32'h2, "prec_mcause");
    rd(12'h300, 32'h0000_1880, "prec_mstatus");
    step(0);

    // interrupt priority
    wr(12'h300, 2'b10, 32'h8);
    wr(12'h304, 2'b01, 32'h888);
    irq_timer = 1; #1;
    check("prio_mti", 32'(irq_cause), 7);
    irq_soft = 1; #1;
    check("prio_msi", 32'(irq_cause), 3);
    irq_ext = 1; #1;
    check("prio_mei", 32'(irq_cause), 11);
    check("prio_req", 32'(irq_req), 1);
    step(0);
    irq_ext = 0; irq_timer = 0; irq_soft = 0;

    // mcycle carry into the high half
    wr(12'hB80, 2'b01, 32'h0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
    rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_written");
    step(0);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_ff");
    step(0);
    rd(12'hB00, 32'h0, "mcycle_lo_wrap");
    rd(12'hB80, 32'h1, "mcycle_hi_carry");
    step(0);
    wr(12'h320, 2'b01, 32'h1);
    rd(12'hB00, 32'h2, "mcycle_inhibit_a");
    step(0);
    step(0);
    rd(12'hB00, 32'h2, "mcycle_inhibit_b");
    step(0);

    // minstret
    wr(12'hB02, 2'b01, 32'h0);
    for (int i = 0; i < 3; i++) begin
      retire = 1; step(0);
      retire = 0; step(0);
    end
    rd(12'hB02, 32'h3, "minstret_three");
    step(0);
    wr(12'h320, 2'b01, 32'h4);
    retire = 1; step(0); retire = 0;
    rd(12'hB02, 32'h3, "minstret_inhibit");
    step(0);
    wr(12'h320, 2'b01, 32'h0);
    retire = 1; addr = 12'hB02; write = 1; write_type = 2'b01; wdata = 32'd10;
    step(0);
    retire = 0; write = 0; write_type = 0;
    rd(12'hB02, 32'd10, "minstret_write_wins");
    step(0);

    // asynchronous reset with no clock edge
    wr(12'h340, 2'b01, 32'hABCD);
    rd(12'h340, 32'hABCD, "pre_reset_mscratch");
    read = 1;
    rst_n = 0; #1;
    check("async_rst_mscratch", rdata, 0);
    check("async_rst_mepc", mepc_out, 0);
    check("async_rst_vector", trap_vector, 32'h4);
    check("async_rst_irq_req", 32'(irq_req), 0);
    read = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    rd(12'h305, 32'h4, "post_rst_mtvec");

    // randomized phase against the reference model
    for (int c = 0; c < 600; c++) begin
      addr       = RND_ADDRS[$urandom_range(0, 19)];
      read       = 1'($urandom_range(0, 1));
      write      = ($urandom_range(0, 2) == 0);
      write_type = 2'($urandom_range(0, 3));
      wdata      = $urandom;
      trap       = ($urandom_range(0, 15) == 0);
      ret        = ($urandom_range(0, 15) == 0);
      trap_irq   = 1'($urandom_range(0, 1));
      trap_cause = 5'($urandom_range(0, 31));
      trap_pc    = $urandom;
      trap_val   = $urandom;
      retire     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) irq_ext   = ~irq_ext;
      if ($urandom_range(0, 3) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 3) == 0) irq_soft  = ~irq_soft;
      step(1);
    end

    read = 0; write = 0; trap = 0; ret = 0; retire = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
